// File: rtl/temporal_encoder_pkg.sv
// Shared types and defaults for the N-gram temporal encoder.
package temporal_encoder_pkg;

    // Default hypervector width (index 0 is the leftmost bit).
    localparam int HV_DIMENSION_DEFAULT = 1024;

    // Default window length N.
    localparam int NGRAM_SIZE_DEFAULT = 3;

    // Controller states: IDLE accepts samples, OUTPUT_STABLE presents a query.
    typedef enum logic {
        IDLE          = 1'b0,
        OUTPUT_STABLE = 1'b1
    } state_t;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int fill_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/temporal_encoder_ngram_history.sv
// History register array for the N-gram encoder. H[k] holds sample t-k
// already rotated k times, so the query is a plain XOR of the array.
// xor_next is the query that the array would hold after an enable edge.
module temporal_encoder_ngram_history
    import temporal_encoder_pkg::*;
#(
    parameter int HV_DIMENSION = HV_DIMENSION_DEFAULT,
    parameter int NGRAM_SIZE   = NGRAM_SIZE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [0:HV_DIMENSION-1] hv_in,
    output logic [0:HV_DIMENSION-1] xor_next
);

    logic [0:HV_DIMENSION-1] hist      [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1] hist_next [NGRAM_SIZE];

    // rho: every bit moves one position toward higher index, the last wraps to 0.
    function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
        return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
    endfunction

    // Next window contents and their XOR reduction.
    always_comb begin
        hist_next[0] = hv_in;
        for (int k = 1; k < NGRAM_SIZE; k++) begin
            hist_next[k] = rho(hist[k-1]);
        end
        xor_next = '0;
        for (int k = 0; k < NGRAM_SIZE; k++) begin
            xor_next = xor_next ^ hist_next[k];
        end
    end

    // Window storage: cleared on reset or flush, shifted on each accepted sample.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            for (int k = 0; k < NGRAM_SIZE; k++) begin
                hist[k] <= '0;
            end
        end else if (enable) begin
            for (int k = 0; k < NGRAM_SIZE; k++) begin
                hist[k] <= hist_next[k];
            end
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// N-gram temporal encoder in front of the associative memory. Each accepted
// sample, once the window holds N samples, yields one registered query
// XOR_k rho^k(HV[t-k]) that is held until the downstream takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer keeps valid and data stable until that edge; ready
// may change freely. ReadyOut_SO depends combinationally on Flush_SI and
// Reset_RBI only; ValidOut_SO and HypervectorOut_DO come from registers.
module temporal_encoder
    import temporal_encoder_pkg::*;
#(
    parameter int HV_DIMENSION = HV_DIMENSION_DEFAULT,
    parameter int NGRAM_SIZE   = NGRAM_SIZE_DEFAULT
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RBI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic                    Flush_SI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output state_t                  state_dbg
);

    localparam int FILL_CNTR_WIDTH = fill_width(NGRAM_SIZE);
    localparam logic [FILL_CNTR_WIDTH-1:0] FILL_MAX = FILL_CNTR_WIDTH'(NGRAM_SIZE);

    state_t                  state;
    state_t                  state_next;
    logic [FILL_CNTR_WIDTH-1:0] fill;
    logic [FILL_CNTR_WIDTH-1:0] fill_inc;
    logic                    accept;
    logic                    window_full;
    logic [0:HV_DIMENSION-1] xor_next;

    assign accept    = ValidIn_SI & ReadyOut_SO;
    assign state_dbg = state;

    // Saturating fill count after a hypothetical accept; full means a query is due.
    always_comb begin
        fill_inc    = (fill == FILL_MAX) ? fill : fill + FILL_CNTR_WIDTH'(1);
        window_full = (fill_inc == FILL_MAX);
    end

    // FSM state register.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; flush wins over every other event.
    always_comb begin
        state_next = state;
        if (Flush_SI) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && window_full) begin
                        state_next = OUTPUT_STABLE;
                    end
                end
                OUTPUT_STABLE: begin
                    if (ReadyIn_SI) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs; both handshake signals are forced low while reset is held.
    always_comb begin
        ReadyOut_SO = 1'b0;
        ValidOut_SO = 1'b0;
        if (Reset_RBI) begin
            case (state)
                IDLE:          ReadyOut_SO = ~Flush_SI;
                OUTPUT_STABLE: ValidOut_SO = 1'b1;
                default:       ReadyOut_SO = 1'b0;
            endcase
        end
    end

    // Fill counter: counts accepted samples up to N, restarts on flush.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI || Flush_SI) begin
            fill <= '0;
        end else if (accept) begin
            fill <= fill_inc;
        end
    end

    // Output buffer: captures the new window XOR on accept, survives a flush.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            HypervectorOut_DO <= '0;
        end else if (accept) begin
            HypervectorOut_DO <= xor_next;
        end
    end

    temporal_encoder_ngram_history #(
        .HV_DIMENSION (HV_DIMENSION),
        .NGRAM_SIZE   (NGRAM_SIZE)
    ) u_history (
        .clk      (Clk_CI),
        .reset_n  (Reset_RBI),
        .enable   (accept),
        .clear    (Flush_SI),
        .hv_in    (HypervectorIn_DI),
        .xor_next (xor_next)
    );

endmodule
